// File: rtl/disp_arbiter.sv
// disp_arbiter: 3-digit display source arbiter (live source A, held/blinking source-B messages); define DISP_ARB_GAP_EN for a blank gap after each message
module disp_arbiter #(
  parameter int HOLD_CYCLES = 24_000_000,
  parameter int BLINK_HALF = 3_000_000,
  parameter int GAP_CYCLES = 1_200_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] a_hex,
  input  logic [2:0]  a_dp,
  input  logic [2:0]  a_en,
  input  logic        lz_blank,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [11:0] b_hex,
  input  logic [2:0]  b_dp,
  input  logic        b_blink,
  input  logic        b_cancel,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [2:0]  dp_out,
  output logic [2:0]  en_out,
  output logic        owner
);
  localparam int MX = HOLD_CYCLES > BLINK_HALF ? (HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES)
                                               : (BLINK_HALF > GAP_CYCLES ? BLINK_HALF : GAP_CYCLES);
  localparam int CW = $clog2(MX) + 1;
`ifdef DISP_ARB_GAP_EN
  typedef enum logic [1:0] {SHOW_A, SHOW_B, GAP} state_t;
  logic [CW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {SHOW_A, SHOW_B} state_t;
`endif
  state_t state;
  logic [CW-1:0] hold_cnt, blink_cnt;
  logic phase;
  logic [11:0] b_hex_q;
  logic [2:0] b_dp_q;
  logic b_blink_q;
  logic show_a, show_b, off;
  logic [2:0] lzmask, nx_dp, nx_en;
  logic [11:0] nx_hex;
  assign b_ready = (state == SHOW_A) & ~reset;
  always_comb begin
    show_a = state == SHOW_A;
    show_b = state == SHOW_B;
    off = b_blink_q & ~phase;
    lzmask = lz_blank ? {|a_hex[11:8], |a_hex[11:4], 1'b1} : 3'b111;
    nx_hex = show_a ? a_hex : show_b ? b_hex_q : 12'h000;
    nx_dp = show_a ? a_dp : (show_b & ~off) ? b_dp_q : 3'b000;
    nx_en = show_a ? (a_en & lzmask) : (show_b & ~off) ? 3'b111 : 3'b000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_A;
      hold_cnt <= '0;
      blink_cnt <= '0;
      phase <= 1'b0;
      b_hex_q <= '0;
      b_dp_q <= '0;
      b_blink_q <= 1'b0;
      {hex2, hex1, hex0} <= '0;
      dp_out <= '0;
      en_out <= '0;
      owner <= 1'b0;
`ifdef DISP_ARB_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      {hex2, hex1, hex0} <= nx_hex;
      dp_out <= nx_dp;
      en_out <= nx_en;
      owner <= ~show_a;
      case (state)
        SHOW_A: if (b_valid) begin
          state <= SHOW_B;
          hold_cnt <= CW'(HOLD_CYCLES - 1);
          blink_cnt <= CW'(BLINK_HALF - 1);
          phase <= 1'b1;
          b_hex_q <= b_hex;
          b_dp_q <= b_dp;
          b_blink_q <= b_blink;
        end
        SHOW_B: begin
          blink_cnt <= blink_cnt == '0 ? CW'(BLINK_HALF - 1) : blink_cnt - CW'(1);
          phase <= blink_cnt == '0 ? ~phase : phase;
          if (b_cancel || hold_cnt == '0) begin
`ifdef DISP_ARB_GAP_EN
            state <= GAP;
            gap_cnt <= CW'(GAP_CYCLES - 1);
`else
            state <= SHOW_A;
`endif
          end else hold_cnt <= hold_cnt - CW'(1);
        end
`ifdef DISP_ARB_GAP_EN
        GAP: if (gap_cnt == '0) state <= SHOW_A; else gap_cnt <= gap_cnt - CW'(1);
`endif
        default: state <= SHOW_A;
      endcase
    end
  end
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed and random checks of disp_arbiter against a mode/time reference model
module tb_disp_arbiter;
  localparam int H = 8;
  localparam int BH = 2;
  localparam int G = 4;
`ifdef DISP_ARB_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] a_hex = '0, b_hex = '0;
  logic [2:0] a_dp = '0, a_en = '0, b_dp = '0;
  logic lz_blank = 1'b0, b_valid = 1'b0, b_blink = 1'b0, b_cancel = 1'b0;
  logic b_ready, owner;
  logic [3:0] hex2, hex1, hex0;
  logic [2:0] dp_out, en_out;
  int n_chk = 0, n_fail = 0;
  int mode = 0, t = 0;
  logic [11:0] mh;
  logic [2:0] mdp;
  logic mbl;

  disp_arbiter #(.HOLD_CYCLES(H), .BLINK_HALF(BH), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .a_hex(a_hex), .a_dp(a_dp), .a_en(a_en), .lz_blank(lz_blank),
    .b_valid(b_valid), .b_ready(b_ready), .b_hex(b_hex), .b_dp(b_dp), .b_blink(b_blink),
    .b_cancel(b_cancel), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out),
    .en_out(en_out), .owner(owner));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Model: mode 0 = live A, 1 = message, 2 = gap; t = cycles spent in current mode.
  task automatic cycle();
    logic [18:0] e;
    logic [2:0] m;
    logic offp;
    int nmode, nt;
    #2;
    chk("ready", 32'(b_ready), 32'((mode == 0) && !reset));
    nmode = mode;
    nt = t + 1;
    if (reset) begin
      e = '0;
      nmode = 0;
      nt = 0;
    end else if (mode == 0) begin
      m = lz_blank ? {a_hex[11:8] != 0, a_hex[11:4] != 0, 1'b1} : 3'b111;
      e = {a_hex, a_dp, a_en & m, 1'b0};
      nt = 0;
      if (b_valid) begin
        nmode = 1;
        mh = b_hex;
        mdp = b_dp;
        mbl = b_blink;
      end
    end else if (mode == 1) begin
      offp = mbl && ((t / BH) % 2 == 1);
      e = {mh, offp ? 3'b000 : mdp, offp ? 3'b000 : 3'b111, 1'b1};
      if (b_cancel || t == H - 1) begin
        nmode = GAP_ON ? 2 : 0;
        nt = 0;
      end
    end else begin
      e = {12'h000, 3'b000, 3'b000, 1'b1};
      if (t == G - 1) begin
        nmode = 0;
        nt = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("disp", 32'({hex2, hex1, hex0, dp_out, en_out, owner}), 32'(e));
    mode = nmode;
    t = nt;
  endtask

  initial begin
    logic [11:0] lzv [4];
    logic [2:0] lze [4];
    logic [23:0] seq;
    int n;
    lzv = '{12'h005, 12'h045, 12'h000, 12'h105};
    lze = '{3'b001, 3'b011, 3'b001, 3'b111};
    repeat (3) cycle();
    chk("reset_en", 32'(en_out), 32'(0));
    reset = 1'b0;
    a_hex = 12'h123;
    a_en = 3'b111;
    a_dp = 3'b010;
    cycle();
    chk("live_hex", 32'({hex2, hex1, hex0}), 32'h123);
    lz_blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_hex = lzv[i];
      cycle();
      chk("lz_en", 32'(en_out), 32'(lze[i]));
    end
    b_hex = 12'hABC;
    b_dp = 3'b100;
    b_valid = 1'b1;
    cycle();
    b_valid = 1'b0;
    b_hex = 12'h000;
    n = 0;
    repeat (3) begin cycle(); n += int'(owner); end
    b_valid = 1'b1;
    b_hex = 12'hFFF;
    repeat (4) begin cycle(); n += int'(owner); end
    b_valid = 1'b0;
    repeat (9) begin cycle(); n += int'(owner); end
    chk("hold_len", 32'(n), 32'(H + GAP_ON * G));
    b_blink = 1'b1;
    b_valid = 1'b1;
    cycle();
    b_valid = 1'b0;
    b_blink = 1'b0;
    seq = '0;
    repeat (8) begin cycle(); seq = {seq[20:0], en_out}; end
    chk("blink_seq", 32'(seq), 32'(24'b111_111_000_000_111_111_000_000));
    repeat (6) cycle();
    b_valid = 1'b1;
    cycle();
    b_valid = 1'b0;
    repeat (2) cycle();
    b_cancel = 1'b1;
    cycle();
    b_cancel = 1'b0;
    cycle();
    chk("cancel_owner", 32'(owner), 32'(GAP_ON));
    repeat (6) cycle();
    b_valid = 1'b1;
    b_cancel = 1'b1;
    cycle();
    b_valid = 1'b0;
    b_cancel = 1'b0;
    cycle();
    chk("cancel_accept", 32'(owner), 32'(1));
    repeat (2) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    chk("mid_reset", 32'({owner, en_out}), 32'(0));
    reset = 1'b0;
    cycle();
    chk("post_reset_owner", 32'(owner), 32'(0));
    repeat (3000) begin
      a_hex = 12'($urandom);
      a_dp = 3'($urandom);
      a_en = 3'($urandom);
      lz_blank = 1'($urandom);
      b_hex = 12'($urandom);
      b_dp = 3'($urandom);
      b_blink = 1'($urandom);
      b_valid = ($urandom % 4) == 0;
      b_cancel = ($urandom % 16) == 0;
      reset = ($urandom % 200) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Owns the 3-digit seven-segment display multiplexer. Its outputs drive the mux's digit, decimal-point and digit-enable inputs directly.
- Source A is a live background value, for example a BCD counter, and is shown whenever no message is active.
- Source B is a message port with a valid/ready handshake. An accepted message pre-empts A for a fixed hold time, optionally blinks, then ownership returns to A.
- Also applies leading-zero blanking to source A.

Parameters:
- HOLD_CYCLES, 24_000_000: number of clk cycles a source-B message is displayed (2 s at 12 MHz); must be >= 1.
- BLINK_HALF, 3_000_000: cycles per blink half-period (on phase, then off phase); must be >= 1.
- GAP_CYCLES, 1_200_000: length of the blank gap in cycles; only used when DISP_ARB_GAP_EN is defined; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_hex  in  12  source A digits: [11:8]=digit2, [7:4]=digit1, [3:0]=digit0
- a_dp  in  3  source A decimal points, active-high
- a_en  in  3  source A digit enables, active-high
- lz_blank  in  1  enables leading-zero blanking of source A
- b_valid  in  1  source B message offered
- b_ready  out  1  arbiter can accept a message
- b_hex  in  12  source B digits, same packing as a_hex
- b_dp  in  3  source B decimal points
- b_blink  in  1  blink the message; sampled at accept
- b_cancel  in  1  abort the active message
- hex2, hex1, hex0  out  4 each  to mux digit inputs (registered)
- dp_out  out  3  to mux dp input (registered)
- en_out  out  3  to mux en input (registered)
- owner  out  1  0 = A shown, 1 = B shown (registered)

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising clk edge with reset=1, all registers clear.
- Reset values:
  - state=SHOW_A; hold and blink counters = 0.
  - hex2/hex1/hex0 = 0, dp_out = 000, en_out = 000, owner = 0.
  - b_ready = 0 while reset is high.
  - Any message in progress is discarded.
- b_ready = (state==SHOW_A) & ~reset, combinational from the state register.
- Accept occurs on an edge where b_valid & b_ready. At accept, b_hex, b_dp and b_blink are latched into internal registers. The source may change them afterwards.
- States:
  - SHOW_A, on accept: go to SHOW_B; hold counter = HOLD_CYCLES-1; blink counter = BLINK_HALF-1; blink phase = on.
  - SHOW_B, when b_cancel=1 or the hold counter reaches 0: go to SHOW_A, or to GAP when the option is compiled in. Otherwise decrement the hold counter.
  - GAP (optional build only): show blank for GAP_CYCLES, then go to SHOW_A.
- b_cancel is ignored outside SHOW_B. b_valid is ignored outside SHOW_A; there is no pre-emption of an active message.
- Output latency: all outputs are registered, one cycle after state or inputs.
  - Accept on edge T: B content and owner=1 appear from the edge after T.
  - B content holds for exactly HOLD_CYCLES cycles.
  - owner=0 with A content again HOLD_CYCLES cycles later.
  - A is live: an a_* change on edge T appears at the outputs after edge T+1.
- Source A output:
  - hex = a_hex, dp_out = a_dp.
  - en_out = a_en & lzmask.
  - lzmask = 111 when lz_blank=0.
  - When lz_blank=1: bit2 = (digit2!=0); bit1 = (digit2!=0)|(digit1!=0); bit0 = 1 (digit0 is never blanked). Example: a_hex=0x005 gives lzmask 001.
- Source B output:
  - hex = latched b_hex; dp_out = latched b_dp; en_out = 111.
  - If blinking, during the off phase en_out=000 and dp_out=000.
  - The blink counter toggles the phase every BLINK_HALF cycles. The first phase is on.
- GAP output: en_out=000, dp_out=000, owner=1.
- Reset asserted mid-message: the message is dropped; after reset, owner=0 and b_ready=1.

Optional Feature:
- Macro: DISP_ARB_GAP_EN.
- Defined: leaving SHOW_B (timeout or cancel) enters GAP for GAP_CYCLES cycles of blank display, with b_ready=0 during GAP, then goes to SHOW_A. This gives a visible separation between the message and the live value.
- Undefined: the GAP state and its counter are not built; SHOW_B goes directly to SHOW_A. GAP_CYCLES is unused.

Test Plan:
- Reset and live display, HOLD_CYCLES=8, BLINK_HALF=2, option off:
  - Hold reset 3 cycles -> all outputs 0, b_ready=0.
  - Release with a_hex=0x123, a_en=111, a_dp=010 -> next cycle hex2/1/0 = 1/2/3, en_out=111, dp_out=010, owner=0, b_ready=1.
- Leading-zero blanking: lz_blank=1 -> en_out follows a_hex:
  - a_hex=0x005 -> en_out=001.
  - a_hex=0x045 -> en_out=011.
  - a_hex=0x000 -> en_out=001.
  - a_hex=0x105 -> en_out=111.
- Message hold:
  - Accept b_hex=0xABC, b_dp=100, b_blink=0 at edge T -> owner=1 and hex=A/B/C for exactly 8 cycles, dp_out=100, en_out=111, b_ready=0.
  - Then A content returns with owner=0.
  - b_valid pulsed during the hold is not accepted.
- Blink: accept with b_blink=1 -> en_out sequence 111,111,000,000,111,111,000,000 over the 8 hold cycles; dp_out=000 whenever en_out=000.
- Cancel and simultaneity:
  - b_cancel at hold cycle 3 -> owner=0 on the following cycle.
  - b_cancel together with b_valid in SHOW_A -> message accepted.
- Option build with DISP_ARB_GAP_EN and GAP_CYCLES=4: after an 8-cycle message -> 4 cycles with en_out=000 and b_ready=0, then owner=0 and b_ready=1.
- Reset asserted during a message -> outputs 0; after release, A content with owner=0.
